tff_mod_counter: RTL and testbench

- Parametrised modulo-M up/down counter built as an array of per-bit toggle flip-flops, each bit's T input derived from the lower bits.
- Successor to the single-bit toggle flip-flop: adds width, modulus, direction, enable, parallel load, terminal-count pulse and a sticky wrap flag.
- Used as a generic tick, divider and address counter in the lab designs.
- One clock domain, synchronous reset.

---
 rtl/tff_mod_counter_if.sv | 23 ++
 rtl/tff_mod_counter.sv | 67 ++++++
 tb/tb_tff_mod_counter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tff_mod_counter_if.sv
// Control/status bundle for tff_mod_counter: controls go master -> slave, state comes back.
interface tff_mod_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_wrap;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrapped;

   modport master (
      output en, up_dn, load, load_val, clr_wrap,
      input  count, tc, wrapped
   );

   modport slave (
      input  en, up_dn, load, load_val, clr_wrap,
      output count, tc, wrapped
   );
endinterface

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter built from per-bit toggle flops, with clamped load,
// registered terminal-count pulse and a sticky wrap flag.
module tff_mod_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 16
) (
   input logic              clk,
   input logic              reset,
   tff_mod_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] toggle;
   logic [WIDTH-1:0] load_sat;
   logic             tc_q, tc_d;
   logic             wrapped_q, wrapped_d;
   logic             wrap;

   // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
   always_comb begin
      toggle    = '0;
      toggle[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         toggle[i] = toggle[i-1] & (bus.up_dn ? count_q[i-1] : ~count_q[i-1]);
      end
   end

   always_comb begin
      wrap     = bus.en & (bus.up_dn ? (count_q == MaxVal) : (count_q == '0));
      load_sat = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
   end

   always_comb begin
      count_d   = count_q;
      tc_d      = 1'b0;
      wrapped_d = wrapped_q & ~bus.clr_wrap;
      if (bus.load) begin
         count_d = load_sat;
      end else if (bus.en) begin
         if (wrap) begin
            // Direct load overrides the toggle pattern so non-power-of-two moduli wrap cleanly.
            count_d   = bus.up_dn ? '0 : MaxVal;
            tc_d      = 1'b1;
            wrapped_d = 1'b1;
         end else begin
            count_d = count_q ^ toggle;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         tc_q      <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         tc_q      <= tc_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.tc      = tc_q;
   assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter: mod-10, full-range mod-8 and mod-2 instances.
module tb_tff_mod_counter;
   logic clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   tff_mod_counter_if #(.WIDTH(4)) bus_a ();
   tff_mod_counter_if #(.WIDTH(3)) bus_b ();
   tff_mod_counter_if #(.WIDTH(2)) bus_c ();

   tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   tff_mod_counter #(.WIDTH(3), .MODULUS(8))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));
   tff_mod_counter #(.WIDTH(2), .MODULUS(2))  dut_c (.clk(clk), .reset(reset), .bus(bus_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input int cnt, input int tc, input int wr);
      check({tag, ".count"}, 32'(bus_a.count), cnt);
      check({tag, ".tc"}, 32'(bus_a.tc), tc);
      check({tag, ".wrapped"}, 32'(bus_a.wrapped), wr);
   endtask

   initial begin
      int tc_pulses;
      reset = 1'b1;
      bus_a.en = 1'b1; bus_a.up_dn = 1'b1; bus_a.load = 1'b1; bus_a.load_val = 4'd5;
      bus_a.clr_wrap = 1'b0;
      bus_b.en = 1'b0; bus_b.up_dn = 1'b1; bus_b.load = 1'b0; bus_b.load_val = '0;
      bus_b.clr_wrap = 1'b0;
      bus_c.en = 1'b0; bus_c.up_dn = 1'b1; bus_c.load = 1'b0; bus_c.load_val = '0;
      bus_c.clr_wrap = 1'b0;
      #1;

      // Reset beats load and en.
      step();
      step();
      check_a("reset", 0, 0, 0);

      // Up count through the mod-10 wrap.
      reset = 1'b0; bus_a.load = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         step();
         check_a($sformatf("up%0d", k), k, 0, 0);
      end
      step();
      check_a("upwrap", 0, 1, 1);
      step();
      check_a("after_upwrap", 1, 0, 1);

      // Down through zero.
      bus_a.up_dn = 1'b0;
      step();
      check_a("down_to0", 0, 0, 1);
      step();
      check_a("downwrap", 9, 1, 1);
      step();
      check_a("down8", 8, 0, 1);
      step();
      check_a("down7", 7, 0, 1);

      // Load, clamp, load+reset.
      bus_a.load = 1'b1; bus_a.load_val = 4'd7; bus_a.up_dn = 1'b1;
      step();
      check_a("load7", 7, 0, 1);
      bus_a.load_val = 4'd13;
      step();
      check_a("load_clamp", 9, 0, 1);
      bus_a.load_val = 4'd9;
      step();
      check_a("load_at_max_no_tc", 9, 0, 1);
      reset = 1'b1; bus_a.load_val = 4'd3;
      step();
      check_a("load_reset", 0, 0, 0);
      reset = 1'b0;

      // Hold at 4.
      bus_a.load_val = 4'd4;
      step();
      bus_a.load = 1'b0; bus_a.en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check_a($sformatf("hold%0d", k), 4, 0, 0);
      end

      // Direction change every enabled cycle.
      bus_a.en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_a.up_dn = (k % 2 == 0);
         step();
         check_a($sformatf("dir%0d", k), (k % 2 == 0) ? 5 : 4, 0, 0);
      end

      // Sticky flag: clear, then wrap+clear together.
      bus_a.load = 1'b1; bus_a.load_val = 4'd9;
      step();
      bus_a.load = 1'b0; bus_a.up_dn = 1'b1;
      step();
      check_a("sticky_wrap", 0, 1, 1);
      bus_a.en = 1'b0; bus_a.clr_wrap = 1'b1;
      step();
      check_a("sticky_clr", 0, 0, 0);
      bus_a.en = 1'b1; bus_a.up_dn = 1'b0;
      step();
      check_a("wrap_beats_clr", 9, 1, 1);
      bus_a.en = 1'b0;
      step();
      check_a("clr_again", 9, 0, 0);
      bus_a.clr_wrap = 1'b0;

      // Full range WIDTH=3, MODULUS=8.
      reset = 1'b1;
      step();
      reset = 1'b0; bus_b.en = 1'b1;
      tc_pulses = 0;
      for (int k = 1; k <= 16; k++) begin
         step();
         check($sformatf("b_up%0d.count", k), 32'(bus_b.count), k % 8);
         check($sformatf("b_up%0d.tc", k), 32'(bus_b.tc), (k % 8 == 0) ? 1 : 0);
         if (bus_b.tc) tc_pulses++;
      end
      check("b_tc_pulses", tc_pulses, 2);
      check("b_wrapped", 32'(bus_b.wrapped), 1);
      bus_b.up_dn = 1'b0;
      step();
      check("b_downwrap.count", 32'(bus_b.count), 7);
      check("b_downwrap.tc", 32'(bus_b.tc), 1);
      bus_b.en = 1'b0; bus_b.load = 1'b1; bus_b.load_val = 3'd6;
      step();
      check("b_load6", 32'(bus_b.count), 6);
      bus_b.load = 1'b0;

      // MODULUS=2 inside a 2-bit counter: back-to-back wraps and clamp.
      reset = 1'b1;
      step();
      reset = 1'b0; bus_c.en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("c_up%0d.count", k), 32'(bus_c.count), k % 2);
         check($sformatf("c_up%0d.tc", k), 32'(bus_c.tc), (k % 2 == 0) ? 1 : 0);
      end
      bus_c.up_dn = 1'b0;
      step();
      check("c_down.count", 32'(bus_c.count), 1);
      check("c_down.tc", 32'(bus_c.tc), 1);
      bus_c.load = 1'b1; bus_c.load_val = 2'd3;
      step();
      check("c_clamp", 32'(bus_c.count), 1);
      check("c_clamp.tc", 32'(bus_c.tc), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
